cpu_control_fsm: RTL and testbench

- Multi-cycle fetch/decode/execute controller that drives the control inputs of the register-file/ALU datapath: register write enables, A/B read selects, immediate select, immediate value, ALU opcode and flags enable.
- Fetches 16-bit instructions over a simple request/valid interface and keeps the program counter.
- Reads the datapath flags to resolve conditional branches.

---
 rtl/cpu_control_fsm.sv | 166 ++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute controller driving the register-file/ALU datapath.
// Optional halt instruction (op=F) enabled by defining CTRL_HALT_EN.
module cpu_control_fsm #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        instr_req,
  output logic [15:0] instr_addr,
  input  logic        instr_valid,
  input  logic [15:0] instr_data,
  input  logic [4:0]  flags,
  output logic [15:0] regEnable,
  output logic [3:0]  a_select,
  output logic [3:0]  b_select,
  output logic        use_imm,
  output logic [15:0] immediate,
  output logic [7:0]  opCode,
  output logic        flagsEn,
  output logic        halted
);

`ifdef CTRL_HALT_EN
  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC} state_t;
`endif

  state_t      state_q;
  logic [15:0] pc_q;
  logic [15:0] ir_q;
  logic        req_q;
  logic [15:0] reg_en_q;
  logic        flags_en_q;
  logic [3:0]  a_sel_q;
  logic [3:0]  b_sel_q;
  logic        use_imm_q;
  logic [15:0] imm_q;
  logic [7:0]  op_q;
  logic        halted_q;

  logic [3:0]  ir_op;
  logic [3:0]  ir_rdest;
  logic [3:0]  ir_ext;
  logic [3:0]  ir_rsrc;
  logic [15:0] imm_sext;
  logic        is_alu;
  logic        is_cmp;
  logic        br_taken_d;
  logic        unused_flags;

  assign ir_op    = ir_q[15:12];
  assign ir_rdest = ir_q[11:8];
  assign ir_ext   = ir_q[7:4];
  assign ir_rsrc  = ir_q[3:0];
  assign imm_sext = {{8{ir_q[7]}}, ir_q[7:0]};
  assign is_alu   = (ir_op <= 4'hB);
  assign is_cmp   = ((ir_op == 4'h0) && (ir_ext == 4'hB)) || (ir_op == 4'hB);

  // F, L and N are not consulted by any branch condition.
  assign unused_flags = ^flags[2:0];

  always_comb begin
    br_taken_d = 1'b0;
    case (ir_rdest)
      4'h0:    br_taken_d = flags[4];
      4'h1:    br_taken_d = ~flags[4];
      4'h2:    br_taken_d = flags[3];
      4'h3:    br_taken_d = ~flags[3];
      4'hE:    br_taken_d = 1'b1;
      default: br_taken_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= PC_RESET;
      ir_q       <= '0;
      req_q      <= 1'b0;
      reg_en_q   <= '0;
      flags_en_q <= 1'b0;
      a_sel_q    <= '0;
      b_sel_q    <= '0;
      use_imm_q  <= 1'b0;
      imm_q      <= '0;
      op_q       <= '0;
      halted_q   <= 1'b0;
    end else begin
      // Write enables are single-cycle pulses; only EXEC re-asserts them.
      reg_en_q   <= '0;
      flags_en_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (instr_valid) begin
            ir_q    <= instr_data;
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end else begin
            req_q   <= 1'b1;
          end
        end
        S_DECODE: begin
          if (ir_op == 4'h0) begin
            op_q      <= {4'h0, ir_ext};
            a_sel_q   <= ir_rdest;
            b_sel_q   <= ir_rsrc;
            use_imm_q <= 1'b0;
          end else if (is_alu) begin
            op_q      <= {ir_op, 4'h0};
            a_sel_q   <= ir_rdest;
            use_imm_q <= 1'b1;
            imm_q     <= imm_sext;
          end
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
          pc_q    <= pc_q + 16'd1;
          if (is_alu) begin
            flags_en_q <= 1'b1;
            if (!is_cmp) begin
              reg_en_q <= 16'h0001 << ir_rdest;
            end
          end else if (ir_op == 4'hC) begin
            pc_q <= br_taken_d ? (pc_q + imm_sext) : (pc_q + 16'd1);
          end
`ifdef CTRL_HALT_EN
          else if (ir_op == 4'hF) begin
            state_q  <= S_HALT;
            req_q    <= 1'b0;
            halted_q <= 1'b1;
            pc_q     <= pc_q;
          end
          // Only reset leaves HALT; every other register keeps its value.
        end
        S_HALT: begin
          state_q <= S_HALT;
`endif
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  assign instr_req  = req_q;
  assign instr_addr = pc_q;
  assign regEnable  = reg_en_q;
  assign a_select   = a_sel_q;
  assign b_select   = b_sel_q;
  assign use_imm    = use_imm_q;
  assign immediate  = imm_q;
  assign opCode     = op_q;
  assign flagsEn    = flags_en_q;
`ifdef CTRL_HALT_EN
  assign halted     = halted_q;
`else
  logic unused_halted;
  assign unused_halted = halted_q;
  assign halted        = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed-vector bench for cpu_control_fsm; expectations are hand-computed per instruction.
module tb_cpu_control_fsm;

  logic        clk;
  logic        reset;
  logic        instr_req;
  logic [15:0] instr_addr;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [4:0]  flags;
  logic [15:0] regEnable;
  logic [3:0]  a_select;
  logic [3:0]  b_select;
  logic        use_imm;
  logic [15:0] immediate;
  logic [7:0]  opCode;
  logic        flagsEn;
  logic        halted;

  int unsigned n_vec;
  int unsigned n_err;

  cpu_control_fsm #(.PC_RESET(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .flags       (flags),
    .regEnable   (regEnable),
    .a_select    (a_select),
    .b_select    (b_select),
    .use_imm     (use_imm),
    .immediate   (immediate),
    .opCode      (opCode),
    .flagsEn     (flagsEn),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction in FETCH and returns just after its EXEC edge.
  task automatic run_instr(input logic [15:0] instr, input logic [4:0] fl);
    check("req_before_fetch", 16'(instr_req), 16'h1);
    instr_valid = 1'b1;
    instr_data  = instr;
    flags       = fl;
    tick();
    instr_valid = 1'b0;
    instr_data  = '0;
    tick();
    tick();
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr_data  = '0;
    flags       = '0;
    tick();
    tick();
    check("rst_pc", instr_addr, 16'h0000);
    check("rst_req", 16'(instr_req), 16'h0);
    check("rst_regen", regEnable, 16'h0000);
    check("rst_opcode", 16'(opCode), 16'h0000);
    check("rst_imm", immediate, 16'h0000);
    check("rst_halted", 16'(halted), 16'h0);
    reset = 1'b0;
    tick();
    check("req_after_rst", 16'(instr_req), 16'h1);

    // Immediate ALU op, checked through decode and exec
    instr_valid = 1'b1;
    instr_data  = 16'h1305;
    tick();
    check("fetch_req_drop", 16'(instr_req), 16'h0);
    instr_valid = 1'b0;
    tick();
    check("dec_opcode", 16'(opCode), 16'h0010);
    check("dec_asel", 16'(a_select), 16'h0003);
    check("dec_useimm", 16'(use_imm), 16'h1);
    check("dec_imm", immediate, 16'h0005);
    check("dec_regen", regEnable, 16'h0000);
    tick();
    check("exe_regen", regEnable, 16'h0008);
    check("exe_flagsen", 16'(flagsEn), 16'h1);
    check("exe_pc", instr_addr, 16'h0001);
    tick();
    check("post_regen", regEnable, 16'h0000);
    check("post_flagsen", 16'(flagsEn), 16'h0);

    for (int i = 0; i < 4; i++) begin
      tick();
      check("wait_req", 16'(instr_req), 16'h1);
      check("wait_addr", instr_addr, 16'h0001);
    end

    run_instr(16'h0251, 5'b00000);
    check("rr_opcode", 16'(opCode), 16'h0005);
    check("rr_asel", 16'(a_select), 16'h0002);
    check("rr_bsel", 16'(b_select), 16'h0001);
    check("rr_useimm", 16'(use_imm), 16'h0);
    check("rr_regen", regEnable, 16'h0004);
    check("rr_pc", instr_addr, 16'h0002);

    run_instr(16'h04B7, 5'b00000);
    check("cmp_opcode", 16'(opCode), 16'h000B);
    check("cmp_bsel", 16'(b_select), 16'h0007);
    check("cmp_flagsen", 16'(flagsEn), 16'h1);
    check("cmp_regen", regEnable, 16'h0000);
    check("cmp_pc", instr_addr, 16'h0003);

    run_instr(16'h2A80, 5'b00000);
    check("imm_opcode", 16'(opCode), 16'h0020);
    check("imm_bsel_held", 16'(b_select), 16'h0007);
    check("imm_sext", immediate, 16'hFF80);
    check("imm_regen", regEnable, 16'h0400);
    check("imm_pc", instr_addr, 16'h0004);

    run_instr(16'hB1FF, 5'b00000);
    check("cmpi_opcode", 16'(opCode), 16'h00B0);
    check("cmpi_regen", regEnable, 16'h0000);
    check("cmpi_flagsen", 16'(flagsEn), 16'h1);

    run_instr(16'hCE0B, 5'b00000);
    check("bal_pc", instr_addr, 16'h0010);
    check("bal_regen", regEnable, 16'h0000);
    check("bal_flagsen", 16'(flagsEn), 16'h0);

    run_instr(16'hC0FE, 5'b10000);
    check("beq_taken_pc", instr_addr, 16'h000E);
    run_instr(16'hCE02, 5'b00000);
    check("bal_fwd_pc", instr_addr, 16'h0010);
    run_instr(16'hC0FE, 5'b00000);
    check("beq_ntaken_pc", instr_addr, 16'h0011);
    run_instr(16'hCE03, 5'b11111);
    check("bal_any_pc", instr_addr, 16'h0014);
    run_instr(16'hC1FE, 5'b00000);
    check("bne_taken_pc", instr_addr, 16'h0012);
    run_instr(16'hC203, 5'b01000);
    check("bcs_taken_pc", instr_addr, 16'h0015);
    run_instr(16'hC303, 5'b01000);
    check("bcc_ntaken_pc", instr_addr, 16'h0016);
    run_instr(16'hC505, 5'b11111);
    check("bad_cond_pc", instr_addr, 16'h0017);
    run_instr(16'hCEE0, 5'b00000);
    check("neg_wrap_pc", instr_addr, 16'hFFF7);
    run_instr(16'hCE09, 5'b00000);
    check("pos_wrap_pc", instr_addr, 16'h0000);
    run_instr(16'hD000, 5'b00000);
    check("nop_pc", instr_addr, 16'h0001);
    check("nop_regen", regEnable, 16'h0000);
    check("nop_flagsen", 16'(flagsEn), 16'h0);

    // Reset landing on the EXEC edge of an ALU op
    instr_valid = 1'b1;
    instr_data  = 16'h1305;
    tick();
    instr_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("rexe_regen", regEnable, 16'h0000);
    check("rexe_flagsen", 16'(flagsEn), 16'h0);
    check("rexe_pc", instr_addr, 16'h0000);
    check("rexe_opcode", 16'(opCode), 16'h0000);
    check("rexe_req", 16'(instr_req), 16'h0);
    reset = 1'b0;
    tick();
    check("rexe_req_after", 16'(instr_req), 16'h1);
    check("rexe_regen_after", regEnable, 16'h0000);

    run_instr(16'hF000, 5'b00000);
`ifdef CTRL_HALT_EN
    check("halt_flag", 16'(halted), 16'h1);
    check("halt_pc", instr_addr, 16'h0000);
    check("halt_req", 16'(instr_req), 16'h0);
    instr_valid = 1'b1;
    instr_data  = 16'h1305;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_hold_req", 16'(instr_req), 16'h0);
      check("halt_hold_pc", instr_addr, 16'h0000);
      check("halt_hold_regen", regEnable, 16'h0000);
      check("halt_hold_flag", 16'(halted), 16'h1);
    end
    instr_valid = 1'b0;
`else
    check("opf_halted", 16'(halted), 16'h0);
    check("opf_pc", instr_addr, 16'h0001);
    check("opf_req", 16'(instr_req), 16'h1);
    check("opf_regen", regEnable, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
